tlb_pipe: RTL and testbench

Parametrised, pipelined successor to the 16-entry fully associative LoongArch TLB. It has the following features:
- TLBNUM entries.
- Per-entry page size: any ps in 12..22, not just 4 KB/4 MB.
- Registered dual search ports with request/response handshake.
- Valid-bit-qualified matching with multi-hit flag.
- Synchronous reset of entry valid bits.
- Round-robin TLBFILL index generator.
- invtlb with separate ASID/VA operands and an error flag.

It sits between the CSR/EXE stages and the IF (port 0) and MEM (port 1) address-translation logic.

---
 rtl/tlb_pipe.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_tlb_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_pipe.sv
// tlb_pipe: fully associative, parametrised TLB with two registered search
// ports, a write port with round-robin fill pointer, invtlb and a
// combinational read port.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   s0_*/s1_*           search request (req, vppn, va_bit12, asid) and
//                       registered response (resp pulse, found, multi,
//                       index, ppn, ps, plv, mat, d, v)
//   we, w_fill, w_*     entry write; w_fill targets fill_index
//   fill_index          current round-robin fill pointer
//   inst_invtlb, invtlb_*  invalidate operation, invtlb_err pulse on op > 6
//   r_index, r_*        combinational read of the stored entry
module tlb_pipe #(
   parameter int TLBNUM = 16,
   localparam int IW = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s0_req,
   input  logic [18:0]   s0_vppn,
   input  logic          s0_va_bit12,
   input  logic [9:0]    s0_asid,
   output logic          s0_resp,
   output logic          s0_found,
   output logic          s0_multi,
   output logic [IW-1:0] s0_index,
   output logic [19:0]   s0_ppn,
   output logic [5:0]    s0_ps,
   output logic [1:0]    s0_plv,
   output logic [1:0]    s0_mat,
   output logic          s0_d,
   output logic          s0_v,
   input  logic          s1_req,
   input  logic [18:0]   s1_vppn,
   input  logic          s1_va_bit12,
   input  logic [9:0]    s1_asid,
   output logic          s1_resp,
   output logic          s1_found,
   output logic          s1_multi,
   output logic [IW-1:0] s1_index,
   output logic [19:0]   s1_ppn,
   output logic [5:0]    s1_ps,
   output logic [1:0]    s1_plv,
   output logic [1:0]    s1_mat,
   output logic          s1_d,
   output logic          s1_v,
   input  logic          we,
   input  logic          w_fill,
   input  logic [IW-1:0] w_index,
   input  logic          w_e,
   input  logic [18:0]   w_vppn,
   input  logic [5:0]    w_ps,
   input  logic [9:0]    w_asid,
   input  logic          w_g,
   input  logic [19:0]   w_ppn0,
   input  logic [19:0]   w_ppn1,
   input  logic [1:0]    w_plv0,
   input  logic [1:0]    w_plv1,
   input  logic [1:0]    w_mat0,
   input  logic [1:0]    w_mat1,
   input  logic          w_d0,
   input  logic          w_d1,
   input  logic          w_v0,
   input  logic          w_v1,
   output logic [IW-1:0] fill_index,
   input  logic          inst_invtlb,
   input  logic [4:0]    invtlb_op,
   input  logic [9:0]    invtlb_asid,
   input  logic [18:0]   invtlb_vppn,
   output logic          invtlb_err,
   input  logic [IW-1:0] r_index,
   output logic          r_e,
   output logic [18:0]   r_vppn,
   output logic [5:0]    r_ps,
   output logic [9:0]    r_asid,
   output logic          r_g,
   output logic [19:0]   r_ppn0,
   output logic [19:0]   r_ppn1,
   output logic [1:0]    r_plv0,
   output logic [1:0]    r_plv1,
   output logic [1:0]    r_mat0,
   output logic [1:0]    r_mat1,
   output logic          r_d0,
   output logic          r_d1,
   output logic          r_v0,
   output logic          r_v1
);

   // Entry storage; only the valid bits are reset.
   logic [TLBNUM-1:0] e_q, e_d;
   logic [18:0] vppn_q [TLBNUM];
   logic [5:0]  ps_q   [TLBNUM];
   logic [9:0]  asid_q [TLBNUM];
   logic        g_q    [TLBNUM];
   logic [19:0] ppn0_q [TLBNUM];
   logic [19:0] ppn1_q [TLBNUM];
   logic [1:0]  plv0_q [TLBNUM];
   logic [1:0]  plv1_q [TLBNUM];
   logic [1:0]  mat0_q [TLBNUM];
   logic [1:0]  mat1_q [TLBNUM];
   logic        d0_q   [TLBNUM];
   logic        d1_q   [TLBNUM];
   logic        v0_q   [TLBNUM];
   logic        v1_q   [TLBNUM];
   logic [IW-1:0] fill_q;
   logic          err_q;

   // Page-size-aware VPPN compare: bits below ps-12 are page offset.
   function automatic logic va_match(input logic [18:0] ent, input logic [18:0] va,
                                     input logic [5:0] ps);
      logic [18:0] mask;
      mask = 19'h7FFFF << (ps - 6'd12);
      return (ps >= 6'd12) && (ps <= 6'd22) && (((ent ^ va) & mask) == 19'h0);
   endfunction

   // Half-page select bit is va[ps], i.e. va_bit12 or vppn[ps-13].
   function automatic logic odd_sel(input logic [18:0] vppn, input logic bit12,
                                    input logic [5:0] ps);
      logic [18:0] sh;
      sh = vppn >> (ps - 6'd13);
      return (ps == 6'd12) ? bit12 : sh[0];
   endfunction

   logic        s_req  [2];
   logic [18:0] s_vppn [2];
   logic        s_b12  [2];
   logic [9:0]  s_asid [2];
   assign s_req[0]  = s0_req;      assign s_req[1]  = s1_req;
   assign s_vppn[0] = s0_vppn;     assign s_vppn[1] = s1_vppn;
   assign s_b12[0]  = s0_va_bit12; assign s_b12[1]  = s1_va_bit12;
   assign s_asid[0] = s0_asid;     assign s_asid[1] = s1_asid;

   logic [TLBNUM-1:0] hit [2];
   logic          odd     [2];
   logic          found_d [2];
   logic          multi_d [2];
   logic [IW-1:0] idx_d   [2];
   logic [19:0]   ppn_d   [2];
   logic [5:0]    ps_d    [2];
   logic [1:0]    plv_d   [2];
   logic [1:0]    mat_d   [2];
   logic          dd_d    [2];
   logic          vv_d    [2];

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         hit[p] = '0;
         idx_d[p] = '0;
         for (int i = 0; i < TLBNUM; i++)
            hit[p][i] = e_q[i] && va_match(vppn_q[i], s_vppn[p], ps_q[i]) &&
                        (g_q[i] || (asid_q[i] == s_asid[p]));
         // Downward scan leaves the lowest hitting index selected.
         for (int i = TLBNUM - 1; i >= 0; i--)
            if (hit[p][i]) idx_d[p] = IW'(i);
         found_d[p] = |hit[p];
         // Clearing the lowest set bit leaves something only on multiple hits.
         multi_d[p] = |(hit[p] & (hit[p] - TLBNUM'(1)));
         odd[p]   = odd_sel(s_vppn[p], s_b12[p], ps_q[idx_d[p]]);
         ppn_d[p] = '0;
         ps_d[p]  = '0;
         plv_d[p] = '0;
         mat_d[p] = '0;
         dd_d[p]  = 1'b0;
         vv_d[p]  = 1'b0;
         if (found_d[p]) begin
            ppn_d[p] = odd[p] ? ppn1_q[idx_d[p]] : ppn0_q[idx_d[p]];
            ps_d[p]  = ps_q[idx_d[p]];
            plv_d[p] = odd[p] ? plv1_q[idx_d[p]] : plv0_q[idx_d[p]];
            mat_d[p] = odd[p] ? mat1_q[idx_d[p]] : mat0_q[idx_d[p]];
            dd_d[p]  = odd[p] ? d1_q[idx_d[p]]   : d0_q[idx_d[p]];
            vv_d[p]  = odd[p] ? v1_q[idx_d[p]]   : v0_q[idx_d[p]];
         end
      end
   end

   logic          resp_q  [2];
   logic          found_q [2];
   logic          multi_q [2];
   logic [IW-1:0] idx_q   [2];
   logic [19:0]   ppn_q   [2];
   logic [5:0]    psr_q   [2];
   logic [1:0]    plv_q   [2];
   logic [1:0]    mat_q   [2];
   logic          dd_q    [2];
   logic          vv_q    [2];

   // Search response stage: results hold until the next request.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (reset) begin
            resp_q[p]  <= 1'b0;
            found_q[p] <= 1'b0;
            multi_q[p] <= 1'b0;
            idx_q[p]   <= '0;
            ppn_q[p]   <= '0;
            psr_q[p]   <= '0;
            plv_q[p]   <= '0;
            mat_q[p]   <= '0;
            dd_q[p]    <= 1'b0;
            vv_q[p]    <= 1'b0;
         end else begin
            resp_q[p] <= s_req[p];
            if (s_req[p]) begin
               found_q[p] <= found_d[p];
               multi_q[p] <= multi_d[p];
               idx_q[p]   <= idx_d[p];
               ppn_q[p]   <= ppn_d[p];
               psr_q[p]   <= ps_d[p];
               plv_q[p]   <= plv_d[p];
               mat_q[p]   <= mat_d[p];
               dd_q[p]    <= dd_d[p];
               vv_q[p]    <= vv_d[p];
            end
         end
      end
   end

   assign s0_resp = resp_q[0]; assign s0_found = found_q[0]; assign s0_multi = multi_q[0];
   assign s0_index = idx_q[0]; assign s0_ppn = ppn_q[0]; assign s0_ps = psr_q[0];
   assign s0_plv = plv_q[0]; assign s0_mat = mat_q[0]; assign s0_d = dd_q[0]; assign s0_v = vv_q[0];
   assign s1_resp = resp_q[1]; assign s1_found = found_q[1]; assign s1_multi = multi_q[1];
   assign s1_index = idx_q[1]; assign s1_ppn = ppn_q[1]; assign s1_ps = psr_q[1];
   assign s1_plv = plv_q[1]; assign s1_mat = mat_q[1]; assign s1_d = dd_q[1]; assign s1_v = vv_q[1];

   logic [IW-1:0]     w_tgt;
   logic [TLBNUM-1:0] inv;
   assign w_tgt = w_fill ? fill_q : w_index;

   always_comb begin
      inv = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         unique case (invtlb_op)
            5'd0, 5'd1: inv[i] = 1'b1;
            5'd2:       inv[i] = g_q[i];
            5'd3:       inv[i] = !g_q[i];
            5'd4:       inv[i] = !g_q[i] && (asid_q[i] == invtlb_asid);
            5'd5:       inv[i] = !g_q[i] && (asid_q[i] == invtlb_asid) &&
                                 va_match(vppn_q[i], invtlb_vppn, ps_q[i]);
            5'd6:       inv[i] = (g_q[i] || (asid_q[i] == invtlb_asid)) &&
                                 va_match(vppn_q[i], invtlb_vppn, ps_q[i]);
            default:    inv[i] = 1'b0;
         endcase
      end
   end

   // Write is applied after invalidation so it wins on the same entry.
   always_comb begin
      e_d = e_q;
      if (inst_invtlb) e_d = e_q & ~inv;
      if (we) e_d[w_tgt] = w_e;
   end

   // Control stage: valid bits, fill pointer, invtlb error pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_q    <= '0;
         fill_q <= '0;
         err_q  <= 1'b0;
      end else begin
         e_q   <= e_d;
         err_q <= inst_invtlb && (invtlb_op > 5'd6);
         // Power-of-two entry count lets the pointer wrap naturally.
         if (we && w_fill) fill_q <= fill_q + IW'(1);
      end
   end

   // Entry payload stage.
   always_ff @(posedge clk) begin
      if (we) begin
         vppn_q[w_tgt] <= w_vppn;
         ps_q[w_tgt]   <= w_ps;
         asid_q[w_tgt] <= w_asid;
         g_q[w_tgt]    <= w_g;
         ppn0_q[w_tgt] <= w_ppn0;
         ppn1_q[w_tgt] <= w_ppn1;
         plv0_q[w_tgt] <= w_plv0;
         plv1_q[w_tgt] <= w_plv1;
         mat0_q[w_tgt] <= w_mat0;
         mat1_q[w_tgt] <= w_mat1;
         d0_q[w_tgt]   <= w_d0;
         d1_q[w_tgt]   <= w_d1;
         v0_q[w_tgt]   <= w_v0;
         v1_q[w_tgt]   <= w_v1;
      end
   end

   assign fill_index = fill_q;
   assign invtlb_err = err_q;

   assign r_e    = e_q[r_index];
   assign r_vppn = vppn_q[r_index];
   assign r_ps   = ps_q[r_index];
   assign r_asid = asid_q[r_index];
   assign r_g    = g_q[r_index];
   assign r_ppn0 = ppn0_q[r_index];
   assign r_ppn1 = ppn1_q[r_index];
   assign r_plv0 = plv0_q[r_index];
   assign r_plv1 = plv1_q[r_index];
   assign r_mat0 = mat0_q[r_index];
   assign r_mat1 = mat1_q[r_index];
   assign r_d0   = d0_q[r_index];
   assign r_d1   = d1_q[r_index];
   assign r_v0   = v0_q[r_index];
   assign r_v1   = v1_q[r_index];

endmodule

// File: tb/tb_tlb_pipe.sv
// Testbench for tlb_pipe: directed scenarios plus randomized traffic,
// checked against a behavioural TLB model held in arrays.
module tb_tlb_pipe;
   localparam int TLBNUM = 16;
   localparam int IW = 4;

   typedef struct packed {
      logic e; logic [18:0] vppn; logic [5:0] ps; logic [9:0] asid; logic g;
      logic [19:0] ppn0; logic [19:0] ppn1; logic [1:0] plv0; logic [1:0] plv1;
      logic [1:0] mat0; logic [1:0] mat1; logic d0; logic d1; logic v0; logic v1;
   } ent_t;
   typedef logic [38:0] res_t;

   logic clk, reset;
   logic s0_req, s0_va_bit12, s1_req, s1_va_bit12;
   logic [18:0] s0_vppn, s1_vppn;
   logic [9:0] s0_asid, s1_asid;
   logic s0_resp, s0_found, s0_multi, s0_d, s0_v, s1_resp, s1_found, s1_multi, s1_d, s1_v;
   logic [IW-1:0] s0_index, s1_index, w_index, fill_index, r_index;
   logic [19:0] s0_ppn, s1_ppn;
   logic [5:0] s0_ps, s1_ps;
   logic [1:0] s0_plv, s0_mat, s1_plv, s1_mat;
   logic we, w_fill, w_e, w_g, w_d0, w_d1, w_v0, w_v1;
   logic [18:0] w_vppn, invtlb_vppn, r_vppn;
   logic [5:0] w_ps, r_ps;
   logic [9:0] w_asid, invtlb_asid, r_asid;
   logic [19:0] w_ppn0, w_ppn1, r_ppn0, r_ppn1;
   logic [1:0] w_plv0, w_plv1, w_mat0, w_mat1, r_plv0, r_plv1, r_mat0, r_mat1;
   logic inst_invtlb, invtlb_err;
   logic [4:0] invtlb_op;
   logic r_e, r_g, r_d0, r_d1, r_v0, r_v1;

   tlb_pipe #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .reset(reset),
      .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
      .s0_resp(s0_resp), .s0_found(s0_found), .s0_multi(s0_multi), .s0_index(s0_index),
      .s0_ppn(s0_ppn), .s0_ps(s0_ps), .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
      .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
      .s1_resp(s1_resp), .s1_found(s1_found), .s1_multi(s1_multi), .s1_index(s1_index),
      .s1_ppn(s1_ppn), .s1_ps(s1_ps), .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
      .we(we), .w_fill(w_fill), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
      .w_asid(w_asid), .w_g(w_g), .w_ppn0(w_ppn0), .w_ppn1(w_ppn1), .w_plv0(w_plv0),
      .w_plv1(w_plv1), .w_mat0(w_mat0), .w_mat1(w_mat1), .w_d0(w_d0), .w_d1(w_d1),
      .w_v0(w_v0), .w_v1(w_v1), .fill_index(fill_index),
      .inst_invtlb(inst_invtlb), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
      .invtlb_vppn(invtlb_vppn), .invtlb_err(invtlb_err),
      .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
      .r_ppn0(r_ppn0), .r_ppn1(r_ppn1), .r_plv0(r_plv0), .r_plv1(r_plv1), .r_mat0(r_mat0),
      .r_mat1(r_mat1), .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   ent_t m  [TLBNUM];
   logic wr [TLBNUM];
   int   m_fill;
   logic m_err;
   res_t exp0, exp1;
   int   vectors, miscompares;

   function automatic logic m_va_match(ent_t t, logic [18:0] vppn);
      int sh;
      if (t.ps < 12 || t.ps > 22) return 1'b0;
      sh = int'(t.ps) - 12;
      return (vppn >> sh) == (t.vppn >> sh);
   endfunction

   function automatic res_t m_search(logic [18:0] vppn, logic b12, logic [9:0] asid);
      int n, first;
      ent_t t;
      logic [31:0] va, sh;
      logic odd;
      n = 0; first = 0;
      for (int i = 0; i < TLBNUM; i++)
         if (m[i].e && m_va_match(m[i], vppn) && (m[i].g || m[i].asid == asid)) begin
            if (n == 0) first = i;
            n++;
         end
      if (n == 0) return {1'b1, 38'b0};
      t = m[first];
      va = {vppn, b12, 12'h000};
      sh = va >> t.ps;
      odd = sh[0];
      return {1'b1, 1'b1, n > 1, 4'(first), odd ? t.ppn1 : t.ppn0, t.ps,
              odd ? t.plv1 : t.plv0, odd ? t.mat1 : t.mat0, odd ? t.d1 : t.d0, odd ? t.v1 : t.v0};
   endfunction

   function automatic logic m_inv(ent_t t);
      logic am, vm;
      am = (t.asid == invtlb_asid);
      vm = m_va_match(t, invtlb_vppn);
      case (invtlb_op)
         5'd0, 5'd1: return 1'b1;
         5'd2: return t.g;
         5'd3: return !t.g;
         5'd4: return !t.g && am;
         5'd5: return !t.g && am && vm;
         5'd6: return (t.g || am) && vm;
         default: return 1'b0;
      endcase
   endfunction

   function automatic res_t dut_res0();
      return {s0_resp, s0_found, s0_multi, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v};
   endfunction
   function automatic res_t dut_res1();
      return {s1_resp, s1_found, s1_multi, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v};
   endfunction
   function automatic ent_t dut_rd();
      return {r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0, r_ppn1, r_plv0, r_plv1,
              r_mat0, r_mat1, r_d0, r_d1, r_v0, r_v1};
   endfunction

   function automatic ent_t rand_ent();
      ent_t t;
      t.e = ($urandom_range(0, 3) != 0);
      t.vppn = 19'($urandom);
      t.ps = ($urandom_range(0, 9) == 0) ? 6'd30 : 6'(12 + $urandom_range(0, 10));
      t.asid = 10'($urandom_range(0, 3));
      t.g = 1'($urandom_range(0, 1));
      t.ppn0 = 20'($urandom); t.ppn1 = 20'($urandom);
      t.plv0 = 2'($urandom); t.plv1 = 2'($urandom);
      t.mat0 = 2'($urandom); t.mat1 = 2'($urandom);
      t.d0 = 1'($urandom); t.d1 = 1'($urandom); t.v0 = 1'($urandom); t.v1 = 1'($urandom);
      return t;
   endfunction

   task automatic idle();
      we = 1'b0; w_fill = 1'b0; s0_req = 1'b0; s1_req = 1'b0; inst_invtlb = 1'b0;
   endtask

   task automatic drive_write(logic fill, logic [IW-1:0] idx, ent_t t);
      we = 1'b1; w_fill = fill; w_index = idx;
      {w_e, w_vppn, w_ps, w_asid, w_g, w_ppn0, w_ppn1, w_plv0, w_plv1,
       w_mat0, w_mat1, w_d0, w_d1, w_v0, w_v1} = t;
   endtask

   // Advance one clock: model the edge from the inputs currently applied.
   task automatic step();
      res_t n0, n1;
      logic [TLBNUM-1:0] inv;
      int tgt;
      logic nerr;
      if (reset) begin
         n0 = '0; n1 = '0;
      end else begin
         n0 = s0_req ? m_search(s0_vppn, s0_va_bit12, s0_asid) : {1'b0, exp0[37:0]};
         n1 = s1_req ? m_search(s1_vppn, s1_va_bit12, s1_asid) : {1'b0, exp1[37:0]};
      end
      for (int i = 0; i < TLBNUM; i++) inv[i] = inst_invtlb && m_inv(m[i]);
      tgt = w_fill ? m_fill : int'(w_index);
      nerr = inst_invtlb && (invtlb_op > 5'd6);
      @(posedge clk);
      exp0 = n0; exp1 = n1;
      if (reset) begin
         for (int i = 0; i < TLBNUM; i++) m[i].e = 1'b0;
         m_fill = 0; m_err = 1'b0;
      end else begin
         for (int i = 0; i < TLBNUM; i++) if (inv[i]) m[i].e = 1'b0;
         if (we) begin
            m[tgt] = {w_e, w_vppn, w_ps, w_asid, w_g, w_ppn0, w_ppn1, w_plv0, w_plv1,
                      w_mat0, w_mat1, w_d0, w_d1, w_v0, w_v1};
            wr[tgt] = 1'b1;
            if (w_fill) m_fill = (m_fill + 1) % TLBNUM;
         end
         m_err = nerr;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; s0_req = 1'b1; s1_req = 1'b1;
      s0_vppn = 19'($urandom); s1_vppn = 19'($urandom);
      step(); step();
      vectors++; if (dut_res0() !== '0) begin miscompares++; $display("FAIL rst_port0 got=%h exp=0", dut_res0()); end
      vectors++; if (dut_res1() !== '0) begin miscompares++; $display("FAIL rst_port1 got=%h exp=0", dut_res1()); end
      vectors++; if (fill_index !== '0 || invtlb_err !== 1'b0) begin miscompares++; $display("FAIL rst_ctrl got fill=%0d err=%b exp 0/0", fill_index, invtlb_err); end
      reset = 1'b0;
      step();
      vectors++; if (s0_resp !== 1'b1 || s0_found !== 1'b0 || dut_res0() !== exp0) begin miscompares++; $display("FAIL rst_search0 got=%h exp=%h", dut_res0(), exp0); end
      vectors++; if (s1_resp !== 1'b1 || s1_found !== 1'b0 || dut_res1() !== exp1) begin miscompares++; $display("FAIL rst_search1 got=%h exp=%h", dut_res1(), exp1); end
      idle();
      for (int i = 0; i < TLBNUM; i++) begin
         r_index = IW'(i); step();
         vectors++; if (r_e !== 1'b0) begin miscompares++; $display("FAIL rst_r_e[%0d] got=%b exp=0", i, r_e); end
      end
   endtask

   task automatic test_write_search();
      ent_t t;
      t = rand_ent(); t.e = 1'b1; t.vppn = 19'h12345; t.ps = 6'd12; t.asid = 10'd5; t.g = 1'b0;
      t.ppn0 = 20'hAAAAA; t.ppn1 = 20'hBBBBB;
      drive_write(1'b0, 4'd3, t); step(); idle();
      s0_req = 1'b1; s0_vppn = 19'h12345; s0_va_bit12 = 1'b1; s0_asid = 10'd5;
      s1_req = 1'b1; s1_vppn = 19'h12345; s1_va_bit12 = 1'b1; s1_asid = 10'd6;
      step(); idle();
      vectors++; if (dut_res0() !== exp0) begin miscompares++; $display("FAIL ws_model0 got=%h exp=%h", dut_res0(), exp0); end
      vectors++; if (s0_found !== 1'b1 || s0_index !== 4'd3 || s0_ppn !== 20'hBBBBB || s0_ps !== 6'd12) begin
         miscompares++; $display("FAIL ws_hit got found=%b idx=%0d ppn=%h ps=%0d exp 1/3/bbbbb/12", s0_found, s0_index, s0_ppn, s0_ps); end
      vectors++; if (s1_found !== 1'b0 || dut_res1() !== exp1) begin miscompares++; $display("FAIL ws_asid_miss got=%h exp=%h", dut_res1(), exp1); end
   endtask

   task automatic test_large_page();
      ent_t t;
      t = rand_ent(); t.e = 1'b1; t.vppn = 19'h40000; t.ps = 6'd21; t.asid = 10'd3; t.g = 1'b1;
      t.ppn0 = 20'h11111; t.ppn1 = 20'h22222;
      drive_write(1'b0, 4'd7, t); step(); idle();
      s0_req = 1'b1; s0_vppn = 19'h400FF; s0_va_bit12 = 1'($urandom); s0_asid = 10'd9;
      step(); idle();
      vectors++; if (dut_res0() !== exp0 || s0_index !== 4'd7 || s0_ppn !== 20'h11111 || s0_multi !== 1'b0) begin
         miscompares++; $display("FAIL lp_hit got=%h exp=%h", dut_res0(), exp0); end
      t.ppn0 = 20'h33333;
      drive_write(1'b0, 4'd2, t); step(); idle();
      s0_req = 1'b1;
      step(); idle();
      vectors++; if (dut_res0() !== exp0 || s0_multi !== 1'b1 || s0_index !== 4'd2 || s0_ppn !== 20'h33333) begin
         miscompares++; $display("FAIL lp_multi got=%h exp=%h", dut_res0(), exp0); end
   endtask

   task automatic test_invtlb();
      ent_t t;
      inst_invtlb = 1'b1; invtlb_op = 5'd4; invtlb_asid = 10'd5; invtlb_vppn = 19'($urandom);
      step(); idle();
      vectors++; if (invtlb_err !== 1'b0) begin miscompares++; $display("FAIL inv4_err got=%b exp=0", invtlb_err); end
      for (int i = 0; i < TLBNUM; i++) begin
         r_index = IW'(i); step();
         vectors++; if (r_e !== (i == 2 || i == 7)) begin miscompares++; $display("FAIL inv4_e[%0d] got=%b exp=%b", i, r_e, (i == 2 || i == 7)); end
      end
      inst_invtlb = 1'b1; invtlb_op = 5'd7;
      step(); idle();
      vectors++; if (invtlb_err !== 1'b1) begin miscompares++; $display("FAIL inv7_err got=%b exp=1", invtlb_err); end
      step();
      vectors++; if (invtlb_err !== 1'b0) begin miscompares++; $display("FAIL inv7_pulse got=%b exp=0", invtlb_err); end
      for (int i = 0; i < TLBNUM; i++) begin
         r_index = IW'(i); step();
         vectors++; if (r_e !== (i == 2 || i == 7)) begin miscompares++; $display("FAIL inv7_e[%0d] got=%b exp=%b", i, r_e, (i == 2 || i == 7)); end
      end
      t = m[3]; t.e = 1'b1;
      drive_write(1'b0, 4'd3, t); inst_invtlb = 1'b1; invtlb_op = 5'd0;
      step(); idle();
      for (int i = 0; i < TLBNUM; i++) begin
         r_index = IW'(i); step();
         vectors++; if (r_e !== (i == 3)) begin miscompares++; $display("FAIL inv0_wr_e[%0d] got=%b exp=%b", i, r_e, (i == 3)); end
      end
   endtask

   task automatic test_same_cycle();
      ent_t t;
      t = rand_ent(); t.e = 1'b1; t.vppn = 19'h55555; t.ps = 6'd12; t.g = 1'b1;
      t.ppn0 = 20'h0CAFE; t.ppn1 = 20'h0BEEF;
      drive_write(1'b0, 4'd1, t);
      s0_req = 1'b1; s0_vppn = 19'h55555; s0_va_bit12 = 1'b0; s0_asid = 10'd0;
      step(); we = 1'b0;
      vectors++; if (s0_found !== 1'b0 || dut_res0() !== exp0) begin miscompares++; $display("FAIL sc_old got=%h exp=%h", dut_res0(), exp0); end
      step(); idle();
      vectors++; if (s0_found !== 1'b1 || s0_index !== 4'd1 || s0_ppn !== 20'h0CAFE || dut_res0() !== exp0) begin
         miscompares++; $display("FAIL sc_new got=%h exp=%h", dut_res0(), exp0); end
   endtask

   task automatic test_back_to_back();
      s0_req = 1'b1; s0_vppn = 19'h12345; s0_va_bit12 = 1'b0; s0_asid = 10'd5;
      s1_req = 1'b1; s1_vppn = 19'h55555; s1_va_bit12 = 1'b1; s1_asid = 10'd7;
      step();
      vectors++; if (dut_res0() !== exp0 || s0_index !== 4'd3 || s0_ppn !== 20'hAAAAA) begin miscompares++; $display("FAIL b2b_a0 got=%h exp=%h", dut_res0(), exp0); end
      vectors++; if (dut_res1() !== exp1 || s1_index !== 4'd1 || s1_ppn !== 20'h0BEEF) begin miscompares++; $display("FAIL b2b_a1 got=%h exp=%h", dut_res1(), exp1); end
      s0_vppn = 19'h55555; s0_va_bit12 = 1'b1;
      s1_vppn = 19'h12345; s1_asid = 10'd6;
      step(); idle();
      vectors++; if (s0_resp !== 1'b1 || s0_index !== 4'd1 || dut_res0() !== exp0) begin miscompares++; $display("FAIL b2b_b0 got=%h exp=%h", dut_res0(), exp0); end
      vectors++; if (s1_resp !== 1'b1 || s1_found !== 1'b0 || dut_res1() !== exp1) begin miscompares++; $display("FAIL b2b_b1 got=%h exp=%h", dut_res1(), exp1); end
      step();
      vectors++; if (s0_resp !== 1'b0 || s0_index !== 4'd1 || dut_res0() !== exp0) begin miscompares++; $display("FAIL b2b_hold0 got=%h exp=%h", dut_res0(), exp0); end
   endtask

   task automatic test_fill();
      for (int k = 0; k < 2 * TLBNUM; k++) begin
         if (k == TLBNUM / 2) begin
            drive_write(1'b0, IW'($urandom), rand_ent()); step(); idle();
            vectors++; if (fill_index !== IW'(k % TLBNUM)) begin miscompares++; $display("FAIL fill_nonfill got=%0d exp=%0d", fill_index, k % TLBNUM); end
         end
         vectors++; if (fill_index !== IW'(k % TLBNUM)) begin miscompares++; $display("FAIL fill_ptr[%0d] got=%0d exp=%0d", k, fill_index, k % TLBNUM); end
         drive_write(1'b1, IW'($urandom), rand_ent()); step(); idle();
      end
      for (int i = 0; i < TLBNUM; i++) begin
         r_index = IW'(i); step();
         vectors++; if (dut_rd() !== m[i]) begin miscompares++; $display("FAIL fill_read[%0d] got=%h exp=%h", i, dut_rd(), m[i]); end
      end
   endtask

   task automatic test_random();
      int j;
      for (int c = 0; c < 600; c++) begin
         idle();
         if ($urandom_range(0, 3) == 0) drive_write(1'($urandom), IW'($urandom), rand_ent());
         if ($urandom_range(0, 9) == 0) begin
            inst_invtlb = 1'b1;
            invtlb_op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(2, 7));
            j = $urandom_range(0, TLBNUM - 1);
            invtlb_asid = m[j].asid; invtlb_vppn = m[j].vppn ^ 19'($urandom_range(0, 255));
         end
         s0_req = 1'($urandom); j = $urandom_range(0, TLBNUM - 1);
         s0_vppn = m[j].vppn ^ 19'($urandom_range(0, 1023)); s0_va_bit12 = 1'($urandom);
         s0_asid = ($urandom_range(0, 3) == 0) ? 10'($urandom) : m[j].asid;
         s1_req = 1'($urandom); j = $urandom_range(0, TLBNUM - 1);
         s1_vppn = m[j].vppn ^ 19'($urandom_range(0, 63)); s1_va_bit12 = 1'($urandom);
         s1_asid = 10'($urandom_range(0, 3));
         r_index = IW'($urandom);
         step();
         vectors++; if (dut_res0() !== exp0) begin miscompares++; $display("FAIL rnd_port0 c=%0d got=%h exp=%h", c, dut_res0(), exp0); end
         vectors++; if (dut_res1() !== exp1) begin miscompares++; $display("FAIL rnd_port1 c=%0d got=%h exp=%h", c, dut_res1(), exp1); end
         vectors++; if (invtlb_err !== m_err || fill_index !== IW'(m_fill)) begin
            miscompares++; $display("FAIL rnd_ctrl c=%0d got err=%b fill=%0d exp %b/%0d", c, invtlb_err, fill_index, m_err, m_fill); end
         vectors++; if (dut_rd() !== m[r_index]) begin miscompares++; $display("FAIL rnd_read c=%0d got=%h exp=%h", c, dut_rd(), m[r_index]); end
      end
      idle();
   endtask

   initial begin
      vectors = 0; miscompares = 0; m_fill = 0; m_err = 1'b0; exp0 = '0; exp1 = '0;
      for (int i = 0; i < TLBNUM; i++) begin m[i] = '0; wr[i] = 1'b0; end
      reset = 1'b0; idle();
      s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0; s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
      w_index = '0; {w_e, w_vppn, w_ps, w_asid, w_g, w_ppn0, w_ppn1, w_plv0, w_plv1,
                     w_mat0, w_mat1, w_d0, w_d1, w_v0, w_v1} = '0;
      invtlb_op = '0; invtlb_asid = '0; invtlb_vppn = '0; r_index = '0;
      test_reset();
      test_write_search();
      test_large_page();
      test_invtlb();
      test_same_cycle();
      test_back_to_back();
      test_fill();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
